// File: rtl/ei_axi4_slave_mem.sv
// AXI4 memory-backed slave: one outstanding write and one outstanding read.
// Supports FIXED/INCR/WRAP full-width bursts over a word-addressed RAM.
module ei_axi4_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 256
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(BYTES);
    localparam int IDXW  = $clog2(DEPTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        if (burst == BURST_FIXED) return BURST_FIXED;
        if (burst == BURST_WRAP && wrap_len_ok(len)) return BURST_WRAP;
        return BURST_INCR;
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) || (burst == BURST_WRAP && !wrap_len_ok(len));
    endfunction

    // Any address bit above the word index means the beat falls outside the RAM.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (LSB + IDXW)) != '0;
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[LSB +: IDXW];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        inc  = a + ADDR_WIDTH'(BYTES);
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LSB) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (a & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [1:0]            wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  w_beat, w_oor, w_last_beat;

    assign awready     = (wstate_q == W_IDLE) && !areset;
    assign wready      = (wstate_q == W_DATA);
    assign bvalid      = (wstate_q == W_RESP);
    assign bid         = bid_q;
    assign bresp       = bresp_q;
    assign w_beat      = wready && wvalid;
    assign w_oor       = out_of_range(waddr_q);
    assign w_last_beat = (wcnt_q == wlen_q);

    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wburst_d = wburst_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        case (wstate_q)
            W_IDLE: if (awvalid && awready) begin
                bid_d    = awid;
                waddr_d  = awaddr;
                wlen_d   = awlen;
                wburst_d = eff_burst(awburst, awlen);
                wcnt_d   = 8'd0;
                bresp_d  = bad_burst(awburst, awlen) ? RESP_SLVERR : RESP_OKAY;
                wstate_d = W_DATA;
            end
            W_DATA: if (w_beat) begin
                // Burst length comes from awlen; a disagreeing wlast only taints the response.
                bresp_d  = resp_max(resp_max(bresp_q, w_oor ? RESP_DECERR : RESP_OKAY),
                                    (wlast != w_last_beat) ? RESP_SLVERR : RESP_OKAY);
                waddr_d  = next_addr(waddr_q, wlen_q, wburst_q);
                wcnt_d   = wcnt_q + 8'd1;
                if (w_last_beat) wstate_d = W_RESP;
            end
            W_RESP: if (bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q <= W_IDLE;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wburst_q <= '0;
            bid_q    <= '0;
            bresp_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wburst_q <= wburst_d;
            bid_q    <= bid_d;
            bresp_q  <= bresp_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_beat && !w_oor) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem_q[word_idx(waddr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    logic [0:0]            rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rd_addr;
    logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rbad_q, rbad_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;
    logic                  rd_oor;

    assign arready = (rstate_q == R_IDLE) && !areset;
    assign rvalid  = (rstate_q == R_DATA);
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    // Registered RAM read: a same-cycle write lands after this read, so reads see old data.
    assign rd_addr = (rstate_q == R_IDLE) ? araddr : raddr_q;
    assign rd_oor  = out_of_range(rd_addr);

    always_comb begin
        rstate_d = rstate_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rburst_d = rburst_q;
        rbad_d   = rbad_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        case (rstate_q)
            R_IDLE: if (arvalid && arready) begin
                rid_d    = arid;
                rlen_d   = arlen;
                rburst_d = eff_burst(arburst, arlen);
                rbad_d   = bad_burst(arburst, arlen);
                rcnt_d   = 8'd0;
                rdata_d  = rd_oor ? '0 : mem_q[word_idx(rd_addr)];
                rresp_d  = rd_oor ? RESP_DECERR :
                           (bad_burst(arburst, arlen) ? RESP_SLVERR : RESP_OKAY);
                rlast_d  = (arlen == 8'd0);
                raddr_d  = next_addr(araddr, arlen, eff_burst(arburst, arlen));
                rstate_d = R_DATA;
            end
            R_DATA: if (rready) begin
                if (rlast_q) begin
                    rstate_d = R_IDLE;
                end else begin
                    rcnt_d  = rcnt_q + 8'd1;
                    rdata_d = rd_oor ? '0 : mem_q[word_idx(rd_addr)];
                    rresp_d = rd_oor ? RESP_DECERR : (rbad_q ? RESP_SLVERR : RESP_OKAY);
                    rlast_d = ((rcnt_q + 8'd1) == rlen_q);
                    raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rstate_q <= R_IDLE;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rburst_q <= '0;
            rbad_q   <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rburst_q <= rburst_d;
            rbad_q   <= rbad_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end
endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed scoreboard bench for ei_axi4_slave_mem: stimulus pushes expected
// B/R responses, a negedge monitor pops and compares on each handshake.
module tb_ei_axi4_slave_mem;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic        aclk, areset;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    ei_axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .DEPTH(256)) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] wd [16];
    logic [31:0] ed [16];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_event(input string name);
        n_total++;
        $display("FAIL %s: got no valid DUT response, required one", name);
    endtask

    // Monitor: compares on handshakes and checks hold-stability across stalls.
    initial begin
        logic b_stall, r_stall, p_rlast;
        logic [3:0] p_bid;
        logic [1:0] p_bresp, p_rresp;
        logic [31:0] p_rdata;
        b_exp_t be;
        r_exp_t re;
        b_stall = 1'b0;
        r_stall = 1'b0;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                if (b_stall && bvalid) begin
                    check("bid_hold", bid, p_bid);
                    check("bresp_hold", bresp, p_bresp);
                end
                if (r_stall && rvalid) begin
                    check("rdata_hold", rdata, p_rdata);
                    check("rlast_hold", rlast, p_rlast);
                    check("rresp_hold", rresp, p_rresp);
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) fail_event("b_unexpected");
                    else begin
                        be = bq.pop_front();
                        check("bid", bid, be.id);
                        check("bresp", bresp, be.resp);
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) fail_event("r_unexpected");
                    else begin
                        re = rq.pop_front();
                        check("rid", rid, re.id);
                        check("rdata", rdata, re.data);
                        check("rresp", rresp, re.resp);
                        check("rlast", rlast, re.last);
                    end
                end
            end
            b_stall = bvalid && !bready;
            r_stall = rvalid && !rready;
            p_bid = bid; p_bresp = bresp;
            p_rdata = rdata; p_rlast = rlast; p_rresp = rresp;
        end
    end

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
        logic ok;
        int n;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk); ok = awready; @(posedge aclk); #1; n++;
        end while (!ok && n < 50);
        awvalid = 1'b0;
        if (!ok) fail_event("aw_handshake");
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic ok;
        int n;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk); ok = wready; @(posedge aclk); #1; n++;
        end while (!ok && n < 50);
        wvalid = 1'b0; wlast = 1'b0;
        if (!ok) fail_event("w_handshake");
    endtask

    task automatic b_phase(input int bwait);
        int k;
        k = 0;
        while (bq.size() > 0 && k < 100) begin
            bready = (k >= bwait); @(posedge aclk); #1; k++;
        end
        bready = 1'b0;
        if (bq.size() > 0) begin fail_event("b_response"); bq.delete(); end
    endtask

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [3:0] strb, input logic [15:0] lastm,
                      input int bwait, input logic [1:0] eresp);
        b_exp_t e;
        e.id = id; e.resp = eresp;
        bq.push_back(e);
        aw_phase(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) w_beat(wd[i], strb, lastm[i]);
        b_phase(bwait);
    endtask

    task automatic rd_go(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [7:0] pat);
        logic ok;
        int n, k;
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        n = 0;
        do begin
            @(negedge aclk); ok = arready; @(posedge aclk); #1; n++;
        end while (!ok && n < 50);
        arvalid = 1'b0;
        if (!ok) fail_event("ar_handshake");
        k = 0;
        while (rq.size() > 0 && k < 200) begin
            rready = pat[3'(k % 8)]; @(posedge aclk); #1; k++;
        end
        rready = 1'b0;
        if (rq.size() > 0) begin fail_event("r_response"); rq.delete(); end
    endtask

    task automatic push_r(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                          input logic last);
        r_exp_t e;
        e.id = id; e.data = d; e.resp = resp; e.last = last;
        rq.push_back(e);
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [1:0] burst, input logic [7:0] pat, input logic [1:0] resp);
        for (int i = 0; i <= int'(len); i++) push_r(id, ed[i], resp, i == int'(len));
        rd_go(id, addr, len, burst, pat);
    endtask

    function automatic logic [15:0] lastm_of(input logic [7:0] len);
        return 16'd1 << len;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, awready, 0);
        check({tag, "_arready"}, arready, 0);
        check({tag, "_wready"}, wready, 0);
        check({tag, "_bvalid"}, bvalid, 0);
        check({tag, "_bid"}, bid, 0);
        check({tag, "_bresp"}, bresp, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rlast"}, rlast, 0);
        check({tag, "_rresp"}, rresp, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        areset = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_idle_outputs("reset");
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("post_reset_awready", awready, 1);
        check("post_reset_arready", arready, 1);
        @(posedge aclk); #1;

        // INCR write and readback
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ed[i] = 32'hA0 + 32'(i); end
        wr(4'd5, 32'h10, 8'd3, INCR, 4'hF, lastm_of(3), 0, OKAY);
        rd(4'd6, 32'h10, 8'd3, INCR, 8'hFF, OKAY);

        // WRAP write: beats land at 0x08, 0x0C, 0x00, 0x04
        for (int i = 0; i < 4; i++) wd[i] = 32'hB0 + 32'(i);
        wr(4'd1, 32'h08, 8'd3, WRAP, 4'hF, lastm_of(3), 0, OKAY);
        for (int i = 0; i < 4; i++) ed[i] = 32'hB0 + 32'(i);
        rd(4'd2, 32'h08, 8'd3, WRAP, 8'hFF, OKAY);
        ed[0] = 32'hB2; ed[1] = 32'hB3; ed[2] = 32'hB0; ed[3] = 32'hB1;
        rd(4'd3, 32'h00, 8'd3, INCR, 8'hFF, OKAY);

        // Illegal WRAP length behaves as INCR with SLVERR
        for (int i = 0; i < 3; i++) begin wd[i] = 32'hC0 + 32'(i); ed[i] = 32'hC0 + 32'(i); end
        wr(4'd7, 32'h20, 8'd2, WRAP, 4'hF, lastm_of(2), 0, SLVERR);
        rd(4'd8, 32'h20, 8'd2, INCR, 8'hFF, OKAY);
        rd(4'd9, 32'h20, 8'd2, WRAP, 8'hFF, SLVERR);

        // Byte strobes, then FIXED read of the merged word
        wd[0] = 32'hFFFF_FFFF;
        wr(4'd1, 32'h30, 8'd0, INCR, 4'hF, lastm_of(0), 0, OKAY);
        wd[0] = 32'h1122_3344;
        wr(4'd2, 32'h30, 8'd0, INCR, 4'b0101, lastm_of(0), 0, OKAY);
        for (int i = 0; i < 3; i++) ed[i] = 32'hFF22_FF44;
        rd(4'hA, 32'h30, 8'd2, FIXED, 8'hFF, OKAY);

        // R stalls with rready 1,0,0,1 and B held five cycles
        for (int i = 0; i < 4; i++) ed[i] = 32'hA0 + 32'(i);
        rd(4'hB, 32'h10, 8'd3, INCR, 8'b1001_1001, OKAY);
        wd[0] = 32'h1234_5678;
        wr(4'h9, 32'h70, 8'd0, INCR, 4'hF, lastm_of(0), 5, OKAY);

        // Out-of-range beats
        push_r(4'h3, 32'h0, DECERR, 1'b1);
        rd_go(4'h3, 32'h400, 8'd0, INCR, 8'hFF);
        wd[0] = 32'hDEAD_BEEF;
        wr(4'h2, 32'h400, 8'd0, INCR, 4'hF, lastm_of(0), 0, DECERR);
        ed[0] = 32'hB2;
        rd(4'h4, 32'h000, 8'd0, INCR, 8'hFF, OKAY);
        wd[0] = 32'h55;
        wr(4'h5, 32'h3FC, 8'd0, INCR, 4'hF, lastm_of(0), 0, OKAY);
        push_r(4'h6, 32'h55, OKAY, 1'b0);
        push_r(4'h6, 32'h0, DECERR, 1'b1);
        rd_go(4'h6, 32'h3FC, 8'd1, INCR, 8'hFF);

        // Early wlast: SLVERR, yet all four beats are written
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hD0 + 32'(i); ed[i] = 32'hD0 + 32'(i); end
        wr(4'hC, 32'h40, 8'd3, INCR, 4'hF, 16'b0010, 0, SLVERR);
        rd(4'hD, 32'h40, 8'd3, INCR, 8'hFF, OKAY);

        // Reset during beat 2 of a 4-beat write
        wd[0] = 32'h77; wd[1] = 32'h88;
        wr(4'h7, 32'h58, 8'd1, INCR, 4'hF, lastm_of(1), 0, OKAY);
        aw_phase(4'h4, 32'h50, 8'd3, INCR);
        w_beat(32'hE0, 4'hF, 1'b0);
        w_beat(32'hE1, 4'hF, 1'b0);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check_idle_outputs("midreset");
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("midreset_rel_awready", awready, 1);
        check("midreset_rel_arready", arready, 1);
        @(posedge aclk); #1;
        wd[0] = 32'h99;
        wr(4'h8, 32'h60, 8'd0, INCR, 4'hF, lastm_of(0), 0, OKAY);
        ed[0] = 32'hE0; ed[1] = 32'hE1; ed[2] = 32'h77; ed[3] = 32'h88;
        rd(4'hE, 32'h50, 8'd3, INCR, 8'hFF, OKAY);

        repeat (3) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ei_axi4_slave_mem.md
Name: ei_axi4_slave_mem

Overview:
AXI4 memory-backed responder (slave) RTL. It is the far end of the VIP master's pif, so the bench drives AW/W/AR and checks B/R against real DUT behaviour. It runs one outstanding write and one outstanding read, and the two directions operate independently. FIXED, INCR and WRAP bursts are supported. Every beat is a full-width transfer; there is no narrow-size support and no size ports.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data bus width: 32 or 64.
ID_WIDTH, 4, transaction ID width.
DEPTH, 256, number of memory words (power of 2).

Ports:
aclk  in  1  clock; all logic on posedge.
areset  in  1  synchronous, active-high reset.
awid  in  ID_WIDTH  write ID.
awaddr  in  ADDR_WIDTH  write start byte address.
awlen  in  8  beats minus 1.
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP.
awvalid  in  1  AW valid.
awready  out  1  AW ready.
wdata  in  DATA_WIDTH  write data.
wstrb  in  DATA_WIDTH/8  byte enables.
wlast  in  1  last write beat.
wvalid  in  1  W valid.
wready  out  1  W ready.
bid  out  ID_WIDTH  echoed awid.
bresp  out  2  write response.
bvalid  out  1  B valid.
bready  in  1  B ready.
arid  in  ID_WIDTH  read ID.
araddr  in  ADDR_WIDTH  read start byte address.
arlen  in  8  beats minus 1.
arburst  in  2  burst type.
arvalid  in  1  AR valid.
arready  out  1  AR ready.
rid  out  ID_WIDTH  echoed arid.
rdata  out  DATA_WIDTH  read data.
rresp  out  2  read response.
rlast  out  1  last read beat.
rvalid  out  1  R valid.
rready  in  1  R ready.

Behaviour:
- Reset (areset=1 at posedge): every output is 0, both FSMs go to IDLE, memory contents are not reset.
  - Reset mid-burst abandons the burst; beats already written stay in memory.
  - awready and arready rise in the first cycle after areset falls.
- Addressing:
  - Word index = addr[LSB +: log2(DEPTH)], where LSB = log2(DATA_WIDTH/8).
  - A beat whose address is at or above DEPTH*DATA_WIDTH/8 is out of range: the write is discarded, the read returns 0, and the burst response becomes DECERR (11).
- Beat address update per burst type:
  - FIXED: address is unchanged.
  - INCR: address += DATA_WIDTH/8. There is no 4KB check.
  - WRAP: aligned to a (len+1)*bytes boundary. Legal len is only 1, 3, 7 or 15.
  - Illegal WRAP len, or burst type 11: treated as INCR, response SLVERR (10).
  - Response priority: DECERR > SLVERR > OKAY. Within a burst the response is sticky.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On the AW handshake, latch id/addr/len/burst, clear the beat count, go to W_DATA.
  - W_DATA: wready=1. Each wvalid&&wready beat writes the bytes enabled by wstrb, then advances addr and count.
  - The beat with count==len ends the burst and goes to W_RESP.
  - If wlast differs from (count==len) on any beat, the response is SLVERR. Termination follows awlen only.
  - W_RESP: bvalid=1, and bid/bresp are held stable until bready. Then return to W_IDLE.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On the AR handshake, latch the fields and register the first beat. rvalid=1 in the next cycle.
  - R_DATA: rdata/rresp/rlast are held stable while rvalid && !rready.
  - On each handshake, the next beat is presented in the following cycle. With rready held high, beats are back-to-back (1 beat/cycle).
  - rlast=1 only when count==len. After the last handshake, go to R_IDLE.
- rid = latched arid on every beat; rresp is per-beat (DECERR applies to the out-of-range beat only).
- Simultaneous write and read of the same word in one cycle: the read returns the old data (read-before-write).
- awlen=0 / arlen=0 are single-beat bursts.

Test Plan:
- Write INCR at 0x10, awlen=3, data 0xA0..0xA3, wstrb=F -> B: bresp=OKAY, bid echoed. Read back INCR 0x10, arlen=3 -> 0xA0..0xA3, with rlast on beat 3 only.
- Write WRAP at 0x08, awlen=3 -> writes land at 0x08, 0x0C, 0x00, 0x04. A matching WRAP read returns the same order. WRAP with awlen=2 -> bresp=SLVERR, addresses follow INCR.
- Write 0x11223344 with wstrb=0101 over a word holding 0xFFFFFFFF -> readback 0xFF22FF44. FIXED read with arlen=2 -> the same word three times.
- Read with rready toggled 1,0,0,1 -> rdata/rlast held stable while stalled; bvalid held 5 cycles with bready low -> bid/bresp unchanged.
- Read at address DEPTH*4 (DATA_WIDTH=32) -> rresp=DECERR, rdata=0. Write there -> bresp=DECERR, memory unchanged. wlast early at beat 1 of awlen=3 -> SLVERR, burst still 4 beats.
- areset pulsed during beat 2 of a 4-beat write -> outputs 0, beats 0-1 retained. awready=1 in the cycle after release, and the next burst completes OKAY.
